// File: rtl/rdata_ch_if.sv
// rtl/rdata_ch_if.sv - R-channel bundle between slaves S0/S1/DS and masters M0/M1
interface rdata_ch_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8
);
  logic [IDS_W-1:0]  S0_RID,   S1_RID,   SD_RID;
  logic [DATA_W-1:0] S0_RData, S1_RData, SD_RData;
  logic [1:0]        S0_RResp, S1_RResp, SD_RResp;
  logic              S0_RLast, S1_RLast, SD_RLast;
  logic              S0_RValid, S1_RValid, SD_RValid;
  logic              S0_RReady, S1_RReady, SD_RReady;

  logic [ID_W-1:0]   M0_RID,   M1_RID;
  logic [DATA_W-1:0] M0_RData, M1_RData;
  logic [1:0]        M0_RResp, M1_RResp;
  logic              M0_RLast, M1_RLast;
  logic              M0_RValid, M1_RValid;
  logic              M0_RReady, M1_RReady;

  // master: the router side, which drives the master-facing R channels
  modport master (
    input  S0_RID, S1_RID, SD_RID, S0_RData, S1_RData, SD_RData,
    input  S0_RResp, S1_RResp, SD_RResp, S0_RLast, S1_RLast, SD_RLast,
    input  S0_RValid, S1_RValid, SD_RValid,
    output S0_RReady, S1_RReady, SD_RReady,
    output M0_RID, M1_RID, M0_RData, M1_RData, M0_RResp, M1_RResp,
    output M0_RLast, M1_RLast, M0_RValid, M1_RValid,
    input  M0_RReady, M1_RReady
  );

  modport slave (
    output S0_RID, S1_RID, SD_RID, S0_RData, S1_RData, SD_RData,
    output S0_RResp, S1_RResp, SD_RResp, S0_RLast, S1_RLast, SD_RLast,
    output S0_RValid, S1_RValid, SD_RValid,
    input  S0_RReady, S1_RReady, SD_RReady,
    input  M0_RID, M1_RID, M0_RData, M1_RData, M0_RResp, M1_RResp,
    input  M0_RLast, M1_RLast, M0_RValid, M1_RValid,
    output M0_RReady, M1_RReady
  );
endinterface

// File: rtl/rdata_ch.sv
// rtl/rdata_ch.sv - AXI R return path: round-robin over S0/S1/DS, burst-locked, routed by ID master index
module rdata_ch #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8
) (
  input  logic      clk,
  input  logic      rst,
  rdata_ch_if.master bus
);

  typedef enum logic {IDLE, BURST} state_t;
  typedef enum logic [1:0] {D_M0 = 2'd0, D_M1 = 2'd1, D_SINK = 2'd2} dest_t;

  state_t     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  dest_t      dest_q,  dest_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;

  logic [2:0]        vld;
  logic [1:0]        win;
  logic [IDS_W-1:0]  win_rid;
  logic [IDS_W-1:0]  sel_rid;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        sel_resp;
  logic              sel_last;
  logic              sel_valid;
  logic              sel_ready;
  logic              hs;
  logic [2:0]        cand;

  assign vld = {bus.SD_RValid, bus.S1_RValid, bus.S0_RValid};

  // Scan from lowest to highest priority so the last hit (rr_ptr itself) wins.
  always_comb begin
    win  = rr_ptr_q;
    cand = '0;
    for (int i = 2; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (vld[cand[1:0]]) win = cand[1:0];
    end
  end

  always_comb begin
    case (win)
      2'd0:    win_rid = bus.S0_RID;
      2'd1:    win_rid = bus.S1_RID;
      default: win_rid = bus.SD_RID;
    endcase
  end

  always_comb begin
    sel_rid   = '0;
    sel_data  = '0;
    sel_resp  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    case (grant_q)
      3'b001: begin
        sel_rid = bus.S0_RID; sel_data = bus.S0_RData; sel_resp = bus.S0_RResp;
        sel_last = bus.S0_RLast; sel_valid = bus.S0_RValid;
      end
      3'b010: begin
        sel_rid = bus.S1_RID; sel_data = bus.S1_RData; sel_resp = bus.S1_RResp;
        sel_last = bus.S1_RLast; sel_valid = bus.S1_RValid;
      end
      3'b100: begin
        sel_rid = bus.SD_RID; sel_data = bus.SD_RData; sel_resp = bus.SD_RResp;
        sel_last = bus.SD_RLast; sel_valid = bus.SD_RValid;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    dest_d   = dest_q;
    rr_ptr_d = rr_ptr_q;
    sel_ready = 1'b0;
    hs        = 1'b0;

    bus.S0_RReady = 1'b0;
    bus.S1_RReady = 1'b0;
    bus.SD_RReady = 1'b0;
    bus.M0_RID    = '0;
    bus.M0_RData  = '0;
    bus.M0_RResp  = '0;
    bus.M0_RLast  = 1'b0;
    bus.M0_RValid = 1'b0;
    bus.M1_RID    = '0;
    bus.M1_RData  = '0;
    bus.M1_RResp  = '0;
    bus.M1_RLast  = 1'b0;
    bus.M1_RValid = 1'b0;

    // Outputs are forced quiet while rst is high, so an abandoned burst is never visible.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (|vld) begin
            state_d = BURST;
            grant_d = 3'b001 << win;
            if (win_rid[IDS_W-1:ID_W] == '0)
              dest_d = D_M0;
            else if (win_rid[IDS_W-1:ID_W] == (IDS_W-ID_W)'(1))
              dest_d = D_M1;
            else
              dest_d = D_SINK;
          end
        end
        BURST: begin
          case (dest_q)
            D_M0: begin
              bus.M0_RID    = sel_rid[ID_W-1:0];
              bus.M0_RData  = sel_data;
              bus.M0_RResp  = sel_resp;
              bus.M0_RLast  = sel_last;
              bus.M0_RValid = sel_valid;
              sel_ready     = bus.M0_RReady;
            end
            D_M1: begin
              bus.M1_RID    = sel_rid[ID_W-1:0];
              bus.M1_RData  = sel_data;
              bus.M1_RResp  = sel_resp;
              bus.M1_RLast  = sel_last;
              bus.M1_RValid = sel_valid;
              sel_ready     = bus.M1_RReady;
            end
            default: sel_ready = 1'b1;
          endcase
          bus.S0_RReady = grant_q[0] & sel_ready;
          bus.S1_RReady = grant_q[1] & sel_ready;
          bus.SD_RReady = grant_q[2] & sel_ready;
          hs = sel_valid & sel_ready;
          if (hs && sel_last) begin
            state_d = IDLE;
            grant_d = '0;
            case (grant_q)
              3'b001:  rr_ptr_d = 2'd1;
              3'b010:  rr_ptr_d = 2'd2;
              default: rr_ptr_d = 2'd0;
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      dest_q   <= D_M0;
      rr_ptr_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      dest_q   <= dest_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_rdata_ch.sv
// tb/tb_rdata_ch.sv - directed bench for rdata_ch with a small slave model and expected-beat queue
module tb_rdata_ch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rdata_ch_if #(.DATA_W(32), .ID_W(4), .IDS_W(8)) bus ();
  rdata_ch #(.DATA_W(32), .ID_W(4), .IDS_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int          s;
    int          m;
    logic [3:0]  id;
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  logic [7:0]  s_rid  [3];
  logic [31:0] s_base [3];
  int          s_n    [3];
  int          s_beat [3];
  logic        s_on   [3];
  int          m_mode [2];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_s(int k, logic v, logic [7:0] id, logic [31:0] d, logic l);
    case (k)
      0: begin bus.S0_RValid = v; bus.S0_RID = id; bus.S0_RData = d; bus.S0_RResp = 2'd0; bus.S0_RLast = l; end
      1: begin bus.S1_RValid = v; bus.S1_RID = id; bus.S1_RData = d; bus.S1_RResp = 2'd1; bus.S1_RLast = l; end
      default: begin bus.SD_RValid = v; bus.SD_RID = id; bus.SD_RData = d; bus.SD_RResp = 2'd2; bus.SD_RLast = l; end
    endcase
  endtask

  function automatic logic s_rdy(int k);
    case (k)
      0: return bus.S0_RReady;
      1: return bus.S1_RReady;
      default: return bus.SD_RReady;
    endcase
  endfunction

  function automatic logic m_val(int m);
    return (m == 0) ? bus.M0_RValid : bus.M1_RValid;
  endfunction

  function automatic logic m_rdy(int m);
    return (m == 0) ? bus.M0_RReady : bus.M1_RReady;
  endfunction

  function automatic logic [38:0] m_pay(int m);
    if (m == 0) return {bus.M0_RID, bus.M0_RData, bus.M0_RResp, bus.M0_RLast};
    return {bus.M1_RID, bus.M1_RData, bus.M1_RResp, bus.M1_RLast};
  endfunction

  task automatic drive(int cyc);
    for (int k = 0; k < 3; k++)
      set_s(k, s_on[k], s_rid[k], s_base[k] + 32'(s_beat[k]), (s_beat[k] == s_n[k] - 1));
    bus.M0_RReady = (m_mode[0] == 0) ? 1'b1 : cyc[0];
    bus.M1_RReady = (m_mode[1] == 0) ? 1'b1 : cyc[0];
  endtask

  task automatic push_burst(int s, int m, logic [7:0] rid, logic [31:0] base, int n);
    s_rid[s] = rid; s_base[s] = base; s_n[s] = n; s_beat[s] = 0; s_on[s] = 1'b1;
    for (int i = 0; i < n; i++)
      exp_q.push_back('{s: s, m: m, id: rid[3:0], d: base + 32'(i), l: (i == n - 1)});
  endtask

  // Runs cycles from an IDLE start until every expected beat is consumed (or the bound hits).
  task automatic run(string tag, int exp_cyc, int stop_after);
    int cyc = 0;
    int hs_k;
    while (exp_q.size() > 0 && cyc < exp_cyc + 8 && (stop_after == 0 || cyc < stop_after)) begin
      drive(cyc);
      @(negedge clk);
      if (cyc == 0) begin
        chk({tag, "_idle_ready"}, {61'd0, bus.S0_RReady, bus.S1_RReady, bus.SD_RReady}, 64'd0);
        chk({tag, "_idle_valid"}, {62'd0, bus.M0_RValid, bus.M1_RValid}, 64'd0);
      end
      for (int m = 0; m < 2; m++) begin
        if (m_val(m)) begin
          chk({tag, "_valid_dest"}, 64'(exp_q.size() > 0 && exp_q[0].m == m), 64'd1);
          if (exp_q.size() > 0 && exp_q[0].m == m) begin
            chk({tag, "_payload"}, 64'(m_pay(m)),
                64'({exp_q[0].id, exp_q[0].d, 2'(exp_q[0].s), exp_q[0].l}));
            chk({tag, "_ready_mirror"}, 64'(s_rdy(exp_q[0].s)), 64'(m_rdy(m)));
          end
        end
      end
      hs_k = -1;
      for (int k = 0; k < 3; k++)
        if (s_on[k] && s_rdy(k)) hs_k = k;
      if (hs_k >= 0) begin
        chk({tag, "_hs_slave"}, 64'(hs_k), (exp_q.size() > 0) ? 64'(exp_q[0].s) : 64'hFFFF);
        if (exp_q.size() > 0) begin
          if (exp_q[0].m == 2)
            chk({tag, "_sink_quiet"}, {62'd0, bus.M0_RValid, bus.M1_RValid}, 64'd0);
          else
            chk({tag, "_hs_master"}, 64'(m_val(exp_q[0].m)), 64'd1);
          void'(exp_q.pop_front());
        end
      end
      @(posedge clk);
      #1;
      if (hs_k >= 0) begin
        s_beat[hs_k]++;
        if (s_beat[hs_k] == s_n[hs_k]) s_on[hs_k] = 1'b0;
      end
      cyc++;
    end
    if (stop_after == 0) begin
      chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
      chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      s_rid[k] = '0; s_base[k] = '0; s_n[k] = 0; s_beat[k] = 0; s_on[k] = 1'b0;
    end
    m_mode[0] = 0; m_mode[1] = 0;
    drive(0);

    // Reset held two cycles with S0 requesting
    rst = 1'b1;
    set_s(0, 1'b1, 8'h01, 32'h55, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", {61'd0, bus.S0_RReady, bus.S1_RReady, bus.SD_RReady}, 64'd0);
      chk("rst_valid", {62'd0, bus.M0_RValid, bus.M1_RValid}, 64'd0);
      chk("rst_m0_pay", 64'(m_pay(0)), 64'd0);
      chk("rst_m1_pay", 64'(m_pay(1)), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    push_burst(1, 1, 8'h13, 32'hA0, 4);
    run("single", 5, 0);

    m_mode[1] = 1;
    push_burst(1, 1, 8'h13, 32'hA0, 4);
    run("bp", 8, 0);
    m_mode[1] = 0;

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_burst(0, 0, 8'h01, 32'h10, 2);
    push_burst(1, 1, 8'h12, 32'h20, 2);
    push_burst(2, 0, 8'h05, 32'h30, 2);
    run("rr", 9, 0);

    push_burst(0, 2, 8'h21, 32'h40, 3);
    run("sink", 4, 0);

    // Reset lands on beat 2 of a 4-beat S1 burst
    push_burst(1, 1, 8'h13, 32'hB0, 4);
    run("midrst", 0, 2);
    rst = 1'b1;
    drive(0);
    @(negedge clk);
    chk("midrst_m1_valid", 64'(bus.M1_RValid), 64'd0);
    chk("midrst_s1_ready", 64'(bus.S1_RReady), 64'd0);
    chk("midrst_m1_pay", 64'(m_pay(1)), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) s_on[k] = 1'b0;
    exp_q.delete();
    push_burst(0, 0, 8'h01, 32'hC0, 2);
    push_burst(1, 1, 8'h13, 32'hD0, 1);
    run("postrst", 5, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
